// File: rtl/seq_comparator.sv
// seq_comparator: bit-serial MSB-first magnitude comparator, unsigned or two's-complement.
module seq_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Gt,
  output logic             Eq,
  output logic             Lt
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [IW-1:0]    idx;
  logic             found, rec_gt;
  logic             diff, bit_gt, fin, differing, res_gt;
  // The sign bit carries negative weight, so its sense flips under signed compare.
  always_comb begin
    diff      = a_q[idx] ^ b_q[idx];
    bit_gt    = (sgn_q && idx == TOP) ? b_q[idx] : a_q[idx];
    fin       = (idx == '0) || (EARLY_EXIT && diff);
    differing = found | diff;
    res_gt    = found ? rec_gt : bit_gt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      idx    <= '0;
      found  <= 1'b0;
      rec_gt <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Gt     <= 1'b0;
      Eq     <= 1'b0;
      Lt     <= 1'b0;
    end else if (state != RUN && start) begin
      state <= RUN;
      a_q   <= A;
      b_q   <= B;
      sgn_q <= is_signed;
      idx   <= TOP;
      found <= 1'b0;
      busy  <= 1'b1;
      done  <= 1'b0;
      Gt    <= 1'b0;
      Eq    <= 1'b0;
      Lt    <= 1'b0;
    end else if (state == RUN) begin
      if (!found && diff) begin
        found  <= 1'b1;
        rec_gt <= bit_gt;
      end
      if (fin) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        Gt    <= differing & res_gt;
        Lt    <= differing & ~res_gt;
        Eq    <= ~differing;
      end else begin
        idx <= idx - 1'b1;
      end
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_comparator.sv
// tb_seq_comparator: randomized and directed checks of seq_comparator against a behavioural model.
module tb_seq_comparator;
  logic clk = 0, rst = 1, start = 0, sgn = 0;
  logic [7:0] a_in = 0, b_in = 0;
  logic busy1, done1, gt1, eq1, lt1;
  logic busy0, done0, gt0, eq0, lt0;
  logic busyw, donew, gtw, eqw, ltw;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  seq_comparator #(.WIDTH(8), .EARLY_EXIT(1)) d1 (.clk(clk), .rst(rst), .start(start), .is_signed(sgn),
    .A(a_in), .B(b_in), .busy(busy1), .done(done1), .Gt(gt1), .Eq(eq1), .Lt(lt1));
  seq_comparator #(.WIDTH(8), .EARLY_EXIT(0)) d0 (.clk(clk), .rst(rst), .start(start), .is_signed(sgn),
    .A(a_in), .B(b_in), .busy(busy0), .done(done0), .Gt(gt0), .Eq(eq0), .Lt(lt0));
  seq_comparator #(.WIDTH(1), .EARLY_EXIT(1)) dw (.clk(clk), .rst(rst), .start(start), .is_signed(sgn),
    .A(a_in[0:0]), .B(b_in[0:0]), .busy(busyw), .done(donew), .Gt(gtw), .Eq(eqw), .Lt(ltw));

  function automatic logic [2:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    if (s) return {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
    return {a > b, a == b, a < b};
  endfunction

  function automatic logic [2:0] model1(input logic a, input logic b, input logic s);
    int va, vb;
    va = s ? -int'(a) : int'(a);
    vb = s ? -int'(b) : int'(b);
    return {va > vb, va == vb, va < vb};
  endfunction

  function automatic int early_lat(input logic [7:0] a, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) if (a[i] != b[i]) return 8 - i;
    return 8;
  endfunction

  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic s, input string nm);
    int lat1 = 0, lat0 = 0, latw = 0, pulses = 0, busy_bad = 0;
    logic [2:0] f1 = 0, f0 = 0, fw = 0, e8, ew;
    e8 = model8(a, b, s);
    ew = model1(a[0], b[0], s);
    a_in = a; b_in = b; sgn = s; start = 1;
    @(posedge clk); #1;
    start = 0; a_in = 8'($urandom); b_in = 8'($urandom); sgn = 1'($urandom);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done1) pulses++;
      if (done1 && lat1 == 0) begin lat1 = n; f1 = {gt1, eq1, lt1}; end
      if (done0 && lat0 == 0) begin lat0 = n; f0 = {gt0, eq0, lt0}; end
      if (donew && latw == 0) begin latw = n; fw = {gtw, eqw, ltw}; end
      if (n < 8 && !(busy0 === 1'b1 && done0 === 1'b0)) busy_bad++;
    end
    tests++; if (lat1 !== early_lat(a, b)) begin fails++; $display("FAIL %s ee1_latency got=%0d exp=%0d", nm, lat1, early_lat(a, b)); end
    tests++; if (f1 !== e8) begin fails++; $display("FAIL %s ee1_flags got=%b exp=%b", nm, f1, e8); end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL %s ee1_done_pulses got=%0d exp=1", nm, pulses); end
    tests++; if ({gt1, eq1, lt1} !== e8) begin fails++; $display("FAIL %s ee1_hold got=%b exp=%b", nm, {gt1, eq1, lt1}, e8); end
    tests++; if (lat0 !== 8) begin fails++; $display("FAIL %s ee0_latency got=%0d exp=8", nm, lat0); end
    tests++; if (f0 !== e8) begin fails++; $display("FAIL %s ee0_flags got=%b exp=%b", nm, f0, e8); end
    tests++; if (busy_bad !== 0) begin fails++; $display("FAIL %s ee0_busy bad_cycles=%0d exp=0", nm, busy_bad); end
    tests++; if (latw !== 1) begin fails++; $display("FAIL %s w1_latency got=%0d exp=1", nm, latw); end
    tests++; if (fw !== ew) begin fails++; $display("FAIL %s w1_flags got=%b exp=%b", nm, fw, ew); end
  endtask

  task automatic test_reset();
    tests++;
    if ({busy1, done1, gt1, eq1, lt1, busy0, done0, gt0, eq0, lt0, busyw, donew, gtw, eqw, ltw} !== 15'b0) begin
      fails++; $display("FAIL reset_outputs got=%b exp=0", {busy1, done1, gt1, eq1, lt1, busy0, done0, gt0, eq0, lt0});
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_directed();
    run_cmp(8'h80, 8'h7F, 0, "u80_7f");
    run_cmp(8'h80, 8'h7F, 1, "s80_7f");
    run_cmp(8'h5A, 8'h5A, 0, "eq5a");
    run_cmp(8'h03, 8'h02, 0, "u03_02");
    run_cmp(8'h80, 8'h00, 0, "u80_00");
    run_cmp(8'hFF, 8'h01, 1, "s_neg1_1");
    run_cmp(8'h81, 8'h81, 1, "s_eq");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom);
      b = (k % 5 == 0) ? a : 8'($urandom);
      run_cmp(a, b, 1'($urandom), "random");
    end
  endtask

  task automatic test_start_in_run();
    int lat = 0;
    logic [2:0] f = 0;
    a_in = 8'h03; b_in = 8'h02; sgn = 0; start = 1;
    @(posedge clk); #1 start = 0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 3) begin start = 1; a_in = 8'h00; b_in = 8'hFF; end
      if (n == 4) start = 0;
      @(posedge clk); #1;
      if (done1 && lat == 0) begin lat = n; f = {gt1, eq1, lt1}; end
    end
    tests++; if (lat !== 8) begin fails++; $display("FAIL run_restart_latency got=%0d exp=8", lat); end
    tests++; if (f !== 3'b100) begin fails++; $display("FAIL run_restart_flags got=%b exp=100", f); end
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    logic [2:0] f = 0;
    a_in = 8'h80; b_in = 8'h7F; sgn = 0; start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    tests++; if ({done1, gt1, eq1, lt1} !== 4'b1100) begin fails++; $display("FAIL b2b_first got=%b exp=1100", {done1, gt1, eq1, lt1}); end
    start = 1; a_in = 8'h03; b_in = 8'h02;
    @(posedge clk); #1 start = 0;
    tests++; if ({busy1, done1, gt1, eq1, lt1} !== 5'b10000) begin fails++; $display("FAIL b2b_restart got=%b exp=10000", {busy1, done1, gt1, eq1, lt1}); end
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (done1 && lat == 0) begin lat = n; f = {gt1, eq1, lt1}; end
    end
    tests++; if (lat !== 8) begin fails++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    tests++; if (f !== 3'b100) begin fails++; $display("FAIL b2b_flags got=%b exp=100", f); end
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    a_in = 8'h03; b_in = 8'h02; sgn = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1; #1;
    tests++;
    if ({busy1, done1, gt1, eq1, lt1, busy0, done0} !== 7'b0) begin
      fails++; $display("FAIL midrun_reset got=%b exp=0", {busy1, done1, gt1, eq1, lt1, busy0, done0});
    end
    repeat (10) begin @(posedge clk); #1; if (done1 || done0) pulses++; end
    rst = 0;
    repeat (10) begin @(posedge clk); #1; if (done1 || done0) pulses++; end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL midrun_no_done got=%0d exp=0", pulses); end
    run_cmp(8'h10, 8'h20, 0, "after_reset");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 The block SHALL run on one clock, with an asynchronous, active-high reset.
REQ-002 Parameter WIDTH, default 8: operand width in bits; legal range 1..64.
REQ-003 Parameter EARLY_EXIT, default 1: 1 means finish at the first differing bit; 0 means always scan all WIDTH bits.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a comparison; accepted only while busy==0.
REQ-007 is_signed  input  1  1 means two's-complement compare; 0 means unsigned; sampled at accept.
REQ-008 A  input  WIDTH  operand A; sampled at accept.
REQ-009 B  input  WIDTH  operand B; sampled at accept.
REQ-010 busy  output  1  high while a comparison is in progress.
REQ-011 done  output  1  one-cycle pulse marking a valid result.
REQ-012 Gt  output  1  result flag for A>B.
REQ-013 Eq  output  1  result flag for A==B.
REQ-014 Lt  output  1  result flag for A<B.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 Transition IDLE->RUN, or DONE->RUN, SHALL occur on a clock edge with start==1.
- On that edge, latch A, B and is_signed.
- Set the bit index to WIDTH-1.
- Clear Gt, Eq and Lt to 0.
REQ-017 start SHALL be ignored in RUN; latched operands SHALL be unaffected by input changes after accept.
REQ-018 Each RUN edge SHALL evaluate one bit at the current index, MSB first.
REQ-019 At the index WIDTH-1 with is_signed==1, the bit sense SHALL be inverted: A=1, B=0 means A<B.
REQ-020 When EARLY_EXIT==1, the first differing bit SHALL set Gt or Lt and move the FSM to DONE on the same edge.
REQ-021 When EARLY_EXIT==0, the first differing bit SHALL be recorded internally.
- Later bits do not change the record.
- The FSM moves to DONE on the edge that evaluates index 0.
REQ-022 If index 0 evaluates with no difference recorded, the result SHALL be Eq=1 and the FSM SHALL move to DONE.
REQ-023 Latency from the accepting edge to the edge that asserts done SHALL be:
- EARLY_EXIT==1: WIDTH-i edges, where i is the highest differing bit index; WIDTH edges when A==B.
- EARLY_EXIT==0: always WIDTH edges.
REQ-024 busy SHALL be 1 exactly while in RUN.
REQ-025 done SHALL be 1 exactly while in DONE, which lasts one cycle; DONE goes to RUN if start==1, otherwise to IDLE.
REQ-026 Gt, Eq and Lt SHALL be one-hot from the DONE entry edge onward.
- They hold their value through IDLE.
- They clear only when the next start is accepted, or on reset.
REQ-027 WIDTH==1 SHALL work with a latency of 1 edge; under is_signed==1 its single bit is the sign bit.
REQ-028 The result SHALL equal the combinational compare of the latched operands, unsigned or signed per the latched is_signed.

Reset
REQ-029 While rst==1, regardless of clk:
- The state SHALL be IDLE.
- busy, done, Gt, Eq and Lt SHALL all be 0.
- The index and the latched operands SHALL be cleared to 0.
REQ-030 Reset asserted during RUN SHALL abort the comparison with no done pulse.
REQ-031 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-032 WIDTH=8, EARLY_EXIT=1, unsigned, A=0x80, B=0x7F -> done after 1 edge, Gt=1, Eq=0, Lt=0.
REQ-033 Same operands with is_signed=1 -> done after 1 edge, Lt=1.
REQ-034 Unsigned compares:
- A=B=0x5A -> done after 8 edges, Eq=1.
- A=0x03, B=0x02 -> done after 8 edges, Gt=1.
REQ-035 EARLY_EXIT=0, A=0x80, B=0x00 -> done after 8 edges, Gt=1; busy stays high for all 8 cycles.
REQ-036 Re-pulsing start with A=0x00, B=0xFF during RUN -> ignored; the original result is reported.
- Start asserted during DONE -> a new run begins the next cycle, and the flags clear.
REQ-037 rst asserted mid-RUN -> all outputs 0 immediately, no done pulse; a following compare A=0x10, B=0x20 -> Lt=1 after 3 edges.
